// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Two-requester arbiter and sequencer for a 1-bit/clock left shifter.
//             Define SHIFT_SEQ_RR_EN for round-robin arbitration (default: fixed).
//  Revision : 1.0  initial release
// ============================================================================
module shift_sequencer #(
   parameter int n  = 4,
   parameter int AW = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req0,
   input  logic [n-1:0]  op0,
   input  logic [AW-1:0] amt0,
   input  logic          req1,
   input  logic [n-1:0]  op1,
   input  logic [AW-1:0] amt1,
   output logic          ack0,
   output logic          ack1,
   output logic [n-1:0]  result,
   output logic          busy,
   output logic [1:0]    gnt,
   output logic          sh_en,
   output logic [n-1:0]  sh_in,
   input  logic [n-1:0]  sh_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [AW-1:0] c_AMT_MAX = AW'(n);

   state_t        r_state;
   state_t        w_next;
   logic [n-1:0]  r_op_q;
   logic [AW-1:0] r_cnt;
   logic          r_first;
   logic          r_amt_nz;
   logic [1:0]    r_gnt;

   logic          w_accept;
   logic          w_pick1;
   logic [n-1:0]  w_op_sel;
   logic [AW-1:0] w_amt_sel;
   logic [AW-1:0] w_amt_clamp;

   assign w_accept = req0 | req1;

`ifdef SHIFT_SEQ_RR_EN
   // r_ptr=1 gives requester 1 priority on a tie; it points away from the last served.
   logic r_ptr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= 1'b0;
      end else if (r_state == DONE) begin
         r_ptr <= r_gnt[0];
      end
   end

   assign w_pick1 = req1 & (~req0 | r_ptr);
`else
   assign w_pick1 = req1 & ~req0;
`endif

   assign w_op_sel    = w_pick1 ? op1  : op0;
   assign w_amt_sel   = w_pick1 ? amt1 : amt0;
   assign w_amt_clamp = (w_amt_sel > c_AMT_MAX) ? c_AMT_MAX : w_amt_sel;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_op_q   <= '0;
         r_cnt    <= '0;
         r_first  <= 1'b0;
         r_amt_nz <= 1'b0;
         r_gnt    <= 2'b00;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op_q   <= w_op_sel;
                  r_cnt    <= w_amt_clamp;
                  r_amt_nz <= (w_amt_clamp != '0);
                  r_first  <= 1'b1;
                  r_gnt    <= w_pick1 ? 2'b10 : 2'b01;
               end
            end
            SHIFT: begin
               r_cnt   <= r_cnt - AW'(1);
               r_first <= 1'b0;
            end
            DONE: begin
               r_gnt <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from state alone so an asynchronous reset clears them at once.
   always_comb begin
      w_next = r_state;
      sh_en  = 1'b0;
      sh_in  = '0;
      result = '0;
      ack0   = 1'b0;
      ack1   = 1'b0;
      gnt    = 2'b00;
      busy   = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = (w_amt_clamp == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            sh_en = 1'b1;
            sh_in = r_first ? r_op_q : sh_out;
            gnt   = r_gnt;
            if (r_cnt == AW'(1)) begin
               w_next = DONE;
            end
         end
         DONE: begin
            result = r_amt_nz ? sh_out : r_op_q;
            ack0   = r_gnt[0];
            ack1   = r_gnt[1];
            gnt    = r_gnt;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_sequencer
//  Purpose  : Randomized scoreboard bench for shift_sequencer with a shifter model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_sequencer;
   localparam int N  = 4;
   localparam int AW = 3;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [N-1:0]  op0 = '0, op1 = '0;
   logic [AW-1:0] amt0 = '0, amt1 = '0;
   logic          ack0, ack1, busy, sh_en;
   logic [N-1:0]  result, sh_in;
   logic [1:0]    gnt;
   logic [N-1:0]  sh_out = '0;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int id;
      int res;
      int ack_cyc;
      int k;
   } exp_t;
   exp_t exp_q[$];

   shift_sequencer #(.n(N), .AW(AW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .op0(op0), .amt0(amt0),
      .req1(req1), .op1(op1), .amt1(amt1),
      .ack0(ack0), .ack1(ack1), .result(result), .busy(busy), .gnt(gnt),
      .sh_en(sh_en), .sh_in(sh_in), .sh_out(sh_out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) if (sh_en) sh_out <= sh_in << 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every acknowledge.
   int   shen_cnt = 0;
   exp_t e;
   always @(negedge clock) begin
      if (!reset_n) begin
         shen_cnt = 0;
      end else begin
         if (sh_en) shen_cnt++;
         if (!busy) check("gnt_idle", int'(gnt), 0);
         if (ack0 || ack1) begin
            check("ack_onehot", int'(ack0 & ack1), 0);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, expected none", ack0, ack1);
            end else begin
               e = exp_q.pop_front();
               check("ack_id", ack1 ? 1 : 0, e.id);
               check("result", int'(result), e.res);
               check("ack_cycle", cyc, e.ack_cyc);
               check("sh_en_cycles", shen_cnt, e.k);
               check("gnt_at_ack", int'(gnt), 1 << e.id);
            end
            shen_cnt = 0;
         end else begin
            check("result_no_ack", int'(result), 0);
         end
      end
   end

   // Requester model: pending flags, held operands, last-served for tie breaking.
   bit            pend[2];
   logic [N-1:0]  opv[2];
   logic [AW-1:0] amv[2];
   int            last_srv = 1;

   task automatic drive_pins();
      req0 = pend[0]; op0 = opv[0]; amt0 = amv[0];
      req1 = pend[1]; op1 = opv[1]; amt1 = amv[1];
   endtask

   task automatic round(input bit new0, input bit new1,
                        input logic [N-1:0] o0, input logic [N-1:0] o1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      int   w;
      int   k;
      bit   got;
      exp_t x;
      if (new0 && !pend[0]) begin pend[0] = 1'b1; opv[0] = o0; amv[0] = a0; end
      if (new1 && !pend[1]) begin pend[1] = 1'b1; opv[1] = o1; amv[1] = a1; end
      drive_pins();
      if (!pend[0] && !pend[1]) begin
         @(negedge clock);
         return;
      end
      if (pend[0] && pend[1]) begin
`ifdef SHIFT_SEQ_RR_EN
         w = (last_srv == 0) ? 1 : 0;
`else
         w = 0;
`endif
      end else begin
         w = pend[0] ? 0 : 1;
      end
      k = (int'(amv[w]) > N) ? N : int'(amv[w]);
      x.id      = w;
      x.res     = (int'(opv[w]) << amv[w]) & ((1 << N) - 1);
      x.ack_cyc = cyc + k + 1;
      x.k       = k;
      exp_q.push_back(x);
      got = 1'b0;
      for (int i = 0; i < N + 8 && !got; i++) begin
         @(negedge clock);
         if ((w == 0) ? ack0 : ack1) got = 1'b1;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: requester %0d got no ack, expected one within %0d cycles", w, k + 1);
         exp_q.delete();
      end
      pend[w]  = 1'b0;
      last_srv = w;
      drive_pins();
      @(negedge clock);
   endtask

   task automatic check_all_zero(input string name);
      check(name, int'({ack0, ack1, busy, gnt, sh_en, sh_in, result}), 0);
   endtask

   initial begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      opv[0] = '0; opv[1] = '0; amv[0] = '0; amv[1] = '0;
      repeat (3) @(negedge clock);
      check_all_zero("reset_state");
      reset_n = 1'b1;
      @(negedge clock);
      check_all_zero("idle_after_reset");

      round(1'b1, 1'b0, 4'b1010, 4'b0000, 3'd1, 3'd0);
      round(1'b0, 1'b1, 4'b0000, 4'b0011, 3'd0, 3'd2);
      round(1'b1, 1'b0, 4'b0110, 4'b0000, 3'd0, 3'd0);
      round(1'b0, 1'b1, 4'b0000, 4'b1111, 3'd0, 3'd7);

      // Both requesters continuously requesting, amount 1.
      for (int i = 0; i < 6; i++) begin
         round(1'b1, 1'b1, 4'(i + 3), 4'(i + 9), 3'd1, 3'd1);
      end

      for (int i = 0; i < 200; i++) begin
         round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      for (int i = 0; i < 8 && (pend[0] || pend[1]); i++) begin
         round(1'b0, 1'b0, 4'b0, 4'b0, 3'd0, 3'd0);
      end

      // Reset in the middle of a shift: operation is abandoned, then rerun.
      pend[0] = 1'b1; opv[0] = 4'b1001; amv[0] = 3'd3;
      drive_pins();
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      check("busy_before_reset", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset_mid_shift");
      @(negedge clock);
      @(negedge clock);
      check_all_zero("held_in_reset");
      last_srv = 1;
      reset_n  = 1'b1;
      round(1'b0, 1'b0, 4'b0, 4'b0, 3'd0, 3'd0);

      repeat (4) @(negedge clock);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
